// File: rtl/coarse_ctrl.sv
// Coarse resolver loop controller for one CDU channel.
// Decodes the high-order read-counter bits into the active-low coarse switch
// selects. Samples the threshold comparators once per reference cycle, after
// the switches have settled. Issues single-clock up/down count requests until
// the coarse error nulls, and steps past the false 180-degree null.
module coarse_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [5:0] rc,
  input  logic       strobe,
  input  logic       _TLC1H,
  input  logic       _TLC2H,
  input  logic       _ADHI,
  output logic       _DC1,
  output logic       _DC2,
  output logic       _DC3,
  output logic       _DC4,
  output logic       _DC5,
  output logic       _DC6,
  output logic       _DC7,
  output logic       _DC8,
  output logic       _DC9,
  output logic       _DC10,
  output logic       _DC11,
  output logic       _DC12,
  output logic       cnt_up,
  output logic       cnt_dn,
  output logic       coarse_null,
  output logic       ambig,
  output logic       tlc_err
);

  typedef enum logic [1:0] {OFF, SETTLE, WAIT, PULSE} state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

  // Active-low switch word for a read-counter value; bit i drives _DC(i+1).
  function automatic logic [11:0] decode(input logic [5:0] r);
    logic [11:0] w;
    w = '1;
    case (r[5:3])
      3'd0, 3'd7: w[0] = 1'b0;
      3'd1, 3'd6: w[1] = 1'b0;
      3'd3, 3'd4: w[2] = 1'b0;
      default:    w[3] = 1'b0;
    endcase
    case (r[5:3])
      3'd0, 3'd3: w[6] = 1'b0;
      3'd1, 3'd2: w[7] = 1'b0;
      3'd4, 3'd7: w[4] = 1'b0;
      default:    w[5] = 1'b0;
    endcase
    w[9]  = ~r[2];
    w[10] = ~r[1];
    w[11] = ~r[0];
    return w;
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [11:0] dc_q, dc_d;
  logic        up_d, dn_d, ambig_d, null_d, err_d;
  logic        dc_chg, false_null;

  assign dc_d   = enable ? decode(rc) : '1;
  assign dc_chg = (dc_d != dc_q);

  // A null facing the wrong way: sine switch at the 0/7 or 3/4 octants with
  // the cosine polarity contradicting it.
  assign false_null = (((rc[5:3] == 3'd0) || (rc[5:3] == 3'd7)) && !_ADHI) ||
                      (((rc[5:3] == 3'd3) || (rc[5:3] == 3'd4)) &&  _ADHI);

  // Next-state, settle counter and sample decisions.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    ambig_d = ambig;
    null_d  = coarse_null;
    err_d   = tlc_err;
    if (!enable) begin
      state_d = OFF;
      cnt_d   = '0;
      ambig_d = 1'b0;
      null_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        OFF: begin
          state_d = SETTLE;
          cnt_d   = SETTLE_LOAD;
        end
        SETTLE: begin
          if (dc_chg) begin
            cnt_d = SETTLE_LOAD;
          end else if (cnt_q <= 8'd1) begin
            cnt_d   = '0;
            state_d = WAIT;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        WAIT: begin
          if (dc_chg) begin
            state_d = SETTLE;
            cnt_d   = SETTLE_LOAD;
          end else if (strobe) begin
            unique case ({_TLC1H, _TLC2H})
              2'b10: begin
                state_d = PULSE;
                up_d    = 1'b1;
                ambig_d = 1'b0;
                null_d  = 1'b0;
              end
              2'b01: begin
                state_d = PULSE;
                dn_d    = 1'b1;
                ambig_d = 1'b0;
                null_d  = 1'b0;
              end
              2'b11: begin
                err_d   = 1'b1;
                ambig_d = 1'b0;
                null_d  = 1'b0;
              end
              2'b00: begin
                // While slewing off a false null, every in-band sample keeps
                // counting up; only a threshold hit ends the slew.
                if (ambig || false_null) begin
                  state_d = PULSE;
                  up_d    = 1'b1;
                  ambig_d = 1'b1;
                  null_d  = 1'b0;
                end else begin
                  null_d  = 1'b1;
                end
              end
            endcase
          end
        end
        PULSE: begin
          state_d = SETTLE;
          cnt_d   = SETTLE_LOAD;
        end
      endcase
    end
  end

  // State, switch word and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= OFF;
      cnt_q       <= '0;
      dc_q        <= '1;
      cnt_up      <= 1'b0;
      cnt_dn      <= 1'b0;
      ambig       <= 1'b0;
      coarse_null <= 1'b0;
      tlc_err     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dc_q        <= dc_d;
      cnt_up      <= up_d;
      cnt_dn      <= dn_d;
      ambig       <= ambig_d;
      coarse_null <= null_d;
      tlc_err     <= err_d;
    end
  end

  assign {_DC12, _DC11, _DC10, _DC9, _DC8, _DC7,
          _DC6,  _DC5,  _DC4,  _DC3, _DC2, _DC1} = dc_q;

endmodule

// File: tb/tb_coarse_ctrl.sv
// Directed bench for coarse_ctrl with SETTLE_CYCLES = 8.
module tb_coarse_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [5:0]  rc;
  logic        strobe;
  logic        _TLC1H, _TLC2H, _ADHI;
  logic [12:1] dc;
  logic        cnt_up, cnt_dn, coarse_null, ambig, tlc_err;
  int          checks = 0;
  int          failures = 0;

  coarse_ctrl #(.SETTLE_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rc(rc), .strobe(strobe),
    ._TLC1H(_TLC1H), ._TLC2H(_TLC2H), ._ADHI(_ADHI),
    ._DC1(dc[1]), ._DC2(dc[2]), ._DC3(dc[3]), ._DC4(dc[4]),
    ._DC5(dc[5]), ._DC6(dc[6]), ._DC7(dc[7]), ._DC8(dc[8]),
    ._DC9(dc[9]), ._DC10(dc[10]), ._DC11(dc[11]), ._DC12(dc[12]),
    .cnt_up(cnt_up), .cnt_dn(cnt_dn), .coarse_null(coarse_null),
    .ambig(ambig), .tlc_err(tlc_err)
  );

  always #5 clk = ~clk;

  // Flags packed as {cnt_up, cnt_dn, ambig, coarse_null, tlc_err}.
  wire [4:0] flags = {cnt_up, cnt_dn, ambig, coarse_null, tlc_err};

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-clock strobe with the given comparator levels; returns just after
  // the sampling edge.
  task automatic sample(input logic t1, input logic t2, input logic adhi);
    strobe = 1'b1; _TLC1H = t1; _TLC2H = t2; _ADHI = adhi;
    step(1);
    strobe = 1'b0; _TLC1H = 1'b0; _TLC2H = 1'b0; _ADHI = 1'b0;
  endtask

  // Change rc (to a different switch word) and wait until WAIT is reached.
  task automatic go_wait(input logic [5:0] v);
    rc = v;
    step(9);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; enable = 1'b0; rc = '0; strobe = 1'b0;
    _TLC1H = 1'b0; _TLC2H = 1'b0; _ADHI = 1'b0;
    step(2);
    checks++;
    if (dc !== 12'hFFF) begin
      failures++; $display("FAIL reset_dc got=%h want=%h", dc, 12'hFFF);
    end
    checks++;
    if (flags !== 5'b00000) begin
      failures++; $display("FAIL reset_flags got=%b want=%b", flags, 5'b00000);
    end
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_enable_settle;
    enable = 1'b1; rc = 6'b000000;
    step(1);
    checks++;
    if (dc !== 12'hFBE) begin
      failures++; $display("FAIL enable_dc got=%h want=%h", dc, 12'hFBE);
    end
    // Strobes held through the whole settle window, including the edge that
    // enters WAIT, must never produce a count.
    strobe = 1'b1; _TLC1H = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      checks++;
      if ({cnt_up, cnt_dn} !== 2'b00) begin
        failures++; $display("FAIL settle_no_count[%0d] got=%b want=00", i, {cnt_up, cnt_dn});
      end
    end
    strobe = 1'b0; _TLC1H = 1'b0;
  endtask

  task automatic test_decode_up;
    rc = 6'b011101;
    step(1);
    checks++;
    if (dc !== 12'h5BB) begin
      failures++; $display("FAIL decode_011101 got=%h want=%h", dc, 12'h5BB);
    end
    step(8);
    sample(1'b1, 1'b0, 1'b0);
    checks++;
    if (flags !== 5'b10000) begin
      failures++; $display("FAIL up_pulse got=%b want=%b", flags, 5'b10000);
    end
    step(1);
    checks++;
    if (flags !== 5'b00000) begin
      failures++; $display("FAIL up_pulse_end got=%b want=%b", flags, 5'b00000);
    end
    step(8);
  endtask

  task automatic test_down_spacing;
    sample(1'b0, 1'b1, 1'b0);
    checks++;
    if (flags !== 5'b01000) begin
      failures++; $display("FAIL dn_pulse got=%b want=%b", flags, 5'b01000);
    end
    step(1);
    checks++;
    if ({cnt_up, cnt_dn} !== 2'b00) begin
      failures++; $display("FAIL dn_pulse_end got=%b want=00", {cnt_up, cnt_dn});
    end
    step(1);
    strobe = 1'b1; _TLC2H = 1'b1;
    step(1);
    strobe = 1'b0; _TLC2H = 1'b0;
    checks++;
    if ({cnt_up, cnt_dn} !== 2'b00) begin
      failures++; $display("FAIL early_strobe got=%b want=00", {cnt_up, cnt_dn});
    end
    step(6);
  endtask

  task automatic test_ambiguity;
    go_wait(6'b000000);
    sample(1'b0, 1'b0, 1'b0);
    checks++;
    if (flags !== 5'b10100) begin
      failures++; $display("FAIL false_null_oct0 got=%b want=%b", flags, 5'b10100);
    end
    step(9);
    sample(1'b0, 1'b0, 1'b0);
    checks++;
    if (flags !== 5'b10100) begin
      failures++; $display("FAIL ambig_repeat got=%b want=%b", flags, 5'b10100);
    end
    step(9);
    sample(1'b1, 1'b0, 1'b0);
    checks++;
    if (flags !== 5'b10000) begin
      failures++; $display("FAIL ambig_clear_tlc1 got=%b want=%b", flags, 5'b10000);
    end
    step(9);
    sample(1'b0, 1'b0, 1'b1);
    checks++;
    if (flags !== 5'b00010) begin
      failures++; $display("FAIL true_null_oct0 got=%b want=%b", flags, 5'b00010);
    end
    go_wait(6'b011000);
    checks++;
    if (dc !== 12'hFBB) begin
      failures++; $display("FAIL decode_oct3 got=%h want=%h", dc, 12'hFBB);
    end
    sample(1'b0, 1'b0, 1'b1);
    checks++;
    if (flags !== 5'b10100) begin
      failures++; $display("FAIL false_null_oct3 got=%b want=%b", flags, 5'b10100);
    end
    step(9);
    sample(1'b0, 1'b1, 1'b0);
    checks++;
    if (flags !== 5'b01000) begin
      failures++; $display("FAIL ambig_clear_tlc2 got=%b want=%b", flags, 5'b01000);
    end
    step(9);
    go_wait(6'b001000);
    checks++;
    if (dc !== 12'hF7D) begin
      failures++; $display("FAIL decode_oct1 got=%h want=%h", dc, 12'hF7D);
    end
    sample(1'b0, 1'b0, 1'b0);
    checks++;
    if (flags !== 5'b00010) begin
      failures++; $display("FAIL null_oct1_no_ambig got=%b want=%b", flags, 5'b00010);
    end
  endtask

  task automatic test_tlc_err;
    sample(1'b1, 1'b1, 1'b0);
    checks++;
    if (flags !== 5'b00001) begin
      failures++; $display("FAIL tlc_err_set got=%b want=%b", flags, 5'b00001);
    end
    step(1);
    checks++;
    if (flags !== 5'b00001) begin
      failures++; $display("FAIL tlc_err_no_pulse got=%b want=%b", flags, 5'b00001);
    end
    enable = 1'b0;
    step(1);
    checks++;
    if (dc !== 12'hFFF) begin
      failures++; $display("FAIL disable_dc got=%h want=%h", dc, 12'hFFF);
    end
    checks++;
    if (flags !== 5'b00000) begin
      failures++; $display("FAIL disable_flags got=%b want=%b", flags, 5'b00000);
    end
  endtask

  task automatic test_rst_mid_pulse;
    enable = 1'b1; rc = 6'b000000;
    step(9);
    sample(1'b1, 1'b0, 1'b0);
    checks++;
    if (flags !== 5'b10000) begin
      failures++; $display("FAIL pre_reset_pulse got=%b want=%b", flags, 5'b10000);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (flags !== 5'b00000) begin
      failures++; $display("FAIL async_reset_flags got=%b want=%b", flags, 5'b00000);
    end
    checks++;
    if (dc !== 12'hFFF) begin
      failures++; $display("FAIL async_reset_dc got=%h want=%h", dc, 12'hFFF);
    end
    step(1);
    rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    test_reset;
    test_enable_settle;
    test_decode_up;
    test_down_spacing;
    test_ambiguity;
    test_tlc_err;
    test_rst_mid_pulse;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
